// File: rtl/synth_cfg_writer_if.sv
// Request channel for synth_cfg_writer: one 16-bit config word write with byte enables.
interface synth_cfg_writer_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_addr;
  logic [15:0] req_data;
  logic [1:0]  req_be;

  modport master (output req_valid, req_addr, req_data, req_be, input req_ready);
  modport slave  (input req_valid, req_addr, req_data, req_be, output req_ready);
endinterface

// File: rtl/synth_cfg_writer.sv
// Serialises 16-bit config writes into strobed byte writes on the synth's ui_in/uio_in pins.
// Strobe phases are stretched so a 2-flop synchroniser plus edge detector sees each byte once.
module synth_cfg_writer #(
  parameter int SETUP_CYCLES = 2,
  parameter int HIGH_CYCLES  = 4,
  parameter int LOW_CYCLES   = 4,
  parameter int CNT_BITS     = 4
) (
  input  logic                clk,
  input  logic                reset,
  synth_cfg_writer_if.slave   req,
  output logic                busy,
  output logic                done,
  output logic [7:0]          pin_ui,
  output logic [7:0]          pin_uio
);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

  localparam logic [CNT_BITS-1:0] SETUP_LD = CNT_BITS'(SETUP_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] HIGH_LD  = CNT_BITS'(HIGH_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] LOW_LD   = CNT_BITS'(LOW_CYCLES - 1);

  state_t              state;
  logic [CNT_BITS-1:0] cnt;
  logic [7:0]          hi_byte;
  logic                hi_pending;
  logic                accept;
  logic                cnt_zero;

  assign req.req_ready = (state == IDLE) && !reset;
  assign accept        = req.req_valid && req.req_ready;
  assign cnt_zero      = (cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      hi_byte    <= '0;
      hi_pending <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pin_ui     <= '0;
      pin_uio    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            hi_byte <= req.req_data[15:8];
            if (req.req_be == 2'b00) begin
              // Nothing to write: acknowledge without touching the pins.
              done <= 1'b1;
            end else begin
              state      <= SETUP;
              cnt        <= SETUP_LD;
              busy       <= 1'b1;
              hi_pending <= &req.req_be;
              pin_ui     <= {1'b0, 3'b000, req.req_addr, ~req.req_be[0]};
              pin_uio    <= req.req_be[0] ? req.req_data[7:0] : req.req_data[15:8];
            end
          end
        end
        SETUP: begin
          if (cnt_zero) begin
            state     <= HIGH;
            cnt       <= HIGH_LD;
            pin_ui[7] <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HIGH: begin
          if (cnt_zero) begin
            state     <= LOW;
            cnt       <= LOW_LD;
            pin_ui[7] <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        LOW: begin
          if (cnt_zero) begin
            if (hi_pending) begin
              // Address stays put; only select and data move to the high byte.
              state      <= SETUP;
              cnt        <= SETUP_LD;
              hi_pending <= 1'b0;
              pin_ui[0]  <= 1'b1;
              pin_uio    <= hi_byte;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_synth_cfg_writer.sv
// Scoreboard bench for synth_cfg_writer: driver pushes expected strobes/done pulses, monitor pops them.
module tb_synth_cfg_writer;
  localparam int S = 2, H = 4, L = 4, P = S + H + L;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       busy, done;
  logic [7:0] pin_ui, pin_uio;

  always #5 clk = ~clk;

  synth_cfg_writer_if rif();

  synth_cfg_writer #(.SETUP_CYCLES(S), .HIGH_CYCLES(H), .LOW_CYCLES(L), .CNT_BITS(4)) dut (
    .clk(clk), .reset(reset), .req(rif), .busy(busy), .done(done),
    .pin_ui(pin_ui), .pin_uio(pin_uio)
  );

  typedef struct {
    int         cyc;
    logic [2:0] addr;
    logic       sel;
    logic [7:0] data;
  } wr_t;

  wr_t  wq[$];
  int   dq[$];
  int   checks = 0, errors = 0;
  int   cyc = 0;
  wr_t  e;
  logic       prev_stb = 1'b0;
  logic [6:0] prev_pins = '0;
  logic [7:0] prev_uio = '0;
  int         hi_cnt = 0;
  logic [15:0] cfg [8];
  logic [15:0] exp_cfg [8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: receiver model (rising strobe = one byte write) plus done checking.
  always @(negedge clk) begin
    if (!reset) begin
      if (pin_ui[7] && !prev_stb) begin
        if (wq.size() == 0) chk("unexpected_strobe", 1, 0);
        else begin
          e = wq.pop_front();
          chk("strobe_cyc", cyc, e.cyc);
          chk("addr", pin_ui[3:1], e.addr);
          chk("sel", pin_ui[0], e.sel);
          chk("data", pin_uio, e.data);
          chk("pad", pin_ui[6:4], 0);
        end
        if (pin_ui[0]) cfg[pin_ui[3:1]][15:8] = pin_uio;
        else           cfg[pin_ui[3:1]][7:0]  = pin_uio;
        hi_cnt = 1;
      end else if (pin_ui[7]) begin
        hi_cnt++;
        chk("stable_high", {pin_ui[6:0], pin_uio}, {prev_pins, prev_uio});
      end else if (prev_stb) begin
        chk("high_len", hi_cnt, H);
      end
      if (done) begin
        if (dq.size() == 0) chk("unexpected_done", 1, 0);
        else chk("done_cyc", cyc, dq.pop_front());
      end
    end
    prev_stb  = pin_ui[7];
    prev_pins = pin_ui[6:0];
    prev_uio  = pin_uio;
  end

  task automatic send(input logic [2:0] a, input logic [15:0] d, input logic [1:0] be,
                      input bit keep, output int acc);
    int t, n;
    wr_t w;
    rif.req_valid = 1'b1;
    rif.req_addr  = a;
    rif.req_data  = d;
    rif.req_be    = be;
    t = 0;
    while (!rif.req_ready && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 200) begin
      chk("accept_timeout", 0, 1);
      rif.req_valid = 1'b0;
      acc = -1;
      return;
    end
    @(posedge clk); #1;
    acc = cyc;
    n = 0;
    if (be[0]) begin
      w.cyc = acc + S; w.addr = a; w.sel = 1'b0; w.data = d[7:0];
      wq.push_back(w); n++;
    end
    if (be[1]) begin
      w.cyc = acc + n * P + S; w.addr = a; w.sel = 1'b1; w.data = d[15:8];
      wq.push_back(w); n++;
    end
    dq.push_back(acc + n * P);
    chk("busy_after_accept", busy, (n != 0));
    if (!keep) rif.req_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((wq.size() != 0 || dq.size() != 0) && t < 500) begin
      @(posedge clk); t++;
    end
    if (t >= 500) chk("drain_timeout", 0, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int a1, a2, acc;
    rif.req_valid = 1'b0;
    rif.req_addr  = '0;
    rif.req_data  = '0;
    rif.req_be    = '0;
    #12;
    chk("rst_pin_ui", pin_ui, 0);
    chk("rst_pin_uio", pin_uio, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", rif.req_ready, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_ready", rif.req_ready, 1);

    send(3'd5, 16'hA1B2, 2'b11, 0, acc); drain();
    send(3'd4, 16'h00FF, 2'b01, 0, acc); drain();
    send(3'd6, 16'h3C00, 2'b10, 0, acc); drain();
    send(3'd7, 16'h5555, 2'b00, 0, acc); drain();

    send(3'd1, 16'h1234, 2'b11, 1, a1);
    send(3'd2, 16'h5678, 2'b11, 0, a2);
    chk("b2b_accept", a2, a1 + 2 * P + 1);
    drain();

    // Reset during the high phase of the low byte.
    send(3'd3, 16'hBEEF, 2'b11, 0, acc);
    while (cyc < acc + S + 1) begin @(posedge clk); #1; end
    #3 reset = 1'b1;
    #1;
    chk("mid_rst_strobe", pin_ui[7], 0);
    chk("mid_rst_pin_ui", pin_ui, 0);
    chk("mid_rst_pin_uio", pin_uio, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", rif.req_ready, 0);
    wq.delete();
    dq.delete();
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", rif.req_ready, 1);
    chk("post_rst_busy", busy, 0);
    repeat (30) @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      exp_cfg[i] = 16'h0F0F + 16'(i) * 16'h1357;
      send(3'(i), exp_cfg[i], 2'b11, (i != 7), acc);
    end
    drain();
    for (int i = 0; i < 8; i++) chk($sformatf("cfg%0d", i), cfg[i], exp_cfg[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
